alu_pipe: RTL

Parametrised, handshaked successor to the 16-bit datapath ALU. It accepts one operation per cycle over a valid/ready input interface and holds a registered result with a full flag set in an output register. It keeps a persistent carry flag for multi-word ADC/SBB chains and optionally runs a multi-cycle shift-add multiplier. It sits between the instruction decode stage and register write-back.

---
 rtl/alu_pipe_pkg.sv | 37 +++
 rtl/alu_pipe_mul.sv | 50 +++++
 rtl/alu_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: opcode encoding, FSM state and the flag bundle.
// The BUSY state is only reachable when ALU_PIPE_MUL_EN is defined.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADC  = 4'd3,
    OP_SBB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ASR  = 4'd11,
    OP_ROL  = 4'd12,
    OP_ROR  = 4'd13,
    OP_CMP  = 4'd14,
    OP_MUL  = 4'd15
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic carry;
    logic sign;
    logic zero;
    logic parity;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// Sequential unsigned shift-add multiplier: bit 0 is folded in on the start edge,
// the remaining WIDTH-1 bits one per cycle; done stays high until the next start.
module alu_pipe_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      count_reg;
  logic               done_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      done_reg   <= 1'b0;
    end else if (start) begin
      acc_reg    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_reg  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_reg <= {1'b0, b[WIDTH-1:1]};
      count_reg  <= CNT_INIT;
      done_reg   <= 1'b0;
    end else if (count_reg != '0) begin
      acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
      mcand_reg  <= {mcand_reg[2*WIDTH-2:0], 1'b0};
      mplier_reg <= {1'b0, mplier_reg[WIDTH-1:1]};
      count_reg  <= count_reg - CNT_ONE;
      done_reg   <= (count_reg == CNT_ONE);
    end
  end

  assign done    = done_reg;
  assign product = acc_reg;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags and persistent carry for ADC/SBB chains.
// Define ALU_PIPE_MUL_EN to add the multi-cycle multiplier (opcode 15, BUSY state).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             sign,
  output logic             zero,
  output logic             parity,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] W_L = (SHW+1)'(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] alu_out_reg;
  flags_t           flags_reg, flags_next;
  logic             out_valid_reg;
  logic             carry_q_reg;

  op_t              op;
  logic             out_free, accept, load, mul_start;
  logic [WIDTH-1:0] res_next, op_res;
  logic             carry_next, ov_next, op_carry, op_ov;

  logic [SHW-1:0]   amt;
  logic [SHW:0]     rot_amt;
  logic             add_cin, sub_cin, add_ov, sub_ov;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, asr_w;
  logic [WIDTH-1:0] rol_v, ror_v;

  assign op       = op_t'(opcode);
  assign out_free = !out_valid_reg || out_ready;
  assign in_ready = (state_reg == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a_in),
    .b       (b_in),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Shifts carry an extra bit at the far end so the last bit shifted out lands there.
  always_comb begin
    amt     = b_in[SHW-1:0];
    add_cin = (op == OP_ADC) ? carry_q_reg : 1'b0;
    sub_cin = (op == OP_SBB) ? carry_q_reg : 1'b0;
    add_w   = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, add_cin};
    sub_w   = {1'b0, a_in} - {1'b0, b_in} - {{WIDTH{1'b0}}, sub_cin};
    add_ov  = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_w[WIDTH-1] != a_in[WIDTH-1]);
    sub_ov  = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub_w[WIDTH-1] != a_in[WIDTH-1]);
    shl_w   = {1'b0, a_in} << amt;
    shr_w   = {a_in, 1'b0} >> amt;
    asr_w   = $signed({a_in, 1'b0}) >>> amt;
    // Amounts can exceed WIDTH-1 when WIDTH is not a power of two.
    rot_amt = ({1'b0, amt} >= W_L) ? ({1'b0, amt} - W_L) : {1'b0, amt};
    rol_v   = (a_in << rot_amt) | (a_in >> (W_L - rot_amt));
    ror_v   = (a_in >> rot_amt) | (a_in << (W_L - rot_amt));

    op_res   = '0;
    op_carry = 1'b0;
    op_ov    = 1'b0;
    case (op)
      OP_PASS: op_res = a_in;
      OP_ADD, OP_ADC: begin
        op_res   = add_w[WIDTH-1:0];
        op_carry = add_w[WIDTH];
        op_ov    = add_ov;
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        op_res   = sub_w[WIDTH-1:0];
        op_carry = sub_w[WIDTH];
        op_ov    = sub_ov;
      end
      OP_AND: op_res = a_in & b_in;
      OP_OR:  op_res = a_in | b_in;
      OP_XOR: op_res = a_in ^ b_in;
      OP_NOT: op_res = ~a_in;
      OP_SHL: begin
        op_res   = shl_w[WIDTH-1:0];
        op_carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        op_res   = shr_w[WIDTH:1];
        op_carry = shr_w[0];
      end
      OP_ASR: begin
        op_res   = asr_w[WIDTH:1];
        op_carry = asr_w[0];
      end
      OP_ROL: op_res = rol_v;
      OP_ROR: op_res = ror_v;
      OP_MUL: op_res = '0;
      default: op_res = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    mul_start  = 1'b0;
    res_next   = op_res;
    carry_next = op_carry;
    ov_next    = op_ov;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (op == OP_MUL) begin
            mul_start  = 1'b1;
            state_next = ST_BUSY;
          end else begin
            load = 1'b1;
          end
`else
          load = 1'b1;
`endif
        end
      end
      ST_BUSY: begin
`ifdef ALU_PIPE_MUL_EN
        res_next   = mul_product[WIDTH-1:0];
        carry_next = |mul_product[2*WIDTH-1:WIDTH];
        ov_next    = |mul_product[2*WIDTH-1:WIDTH];
        // A finished product waits here until the output register frees up.
        if (mul_done && out_free) begin
          load       = 1'b1;
          state_next = ST_IDLE;
        end
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
    flags_next.carry    = carry_next;
    flags_next.sign     = res_next[WIDTH-1];
    flags_next.zero     = (res_next == '0);
    flags_next.parity   = ^res_next;
    flags_next.overflow = ov_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      alu_out_reg   <= '0;
      flags_reg     <= '0;
      out_valid_reg <= 1'b0;
      carry_q_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        alu_out_reg   <= res_next;
        flags_reg     <= flags_next;
        out_valid_reg <= 1'b1;
        carry_q_reg   <= flags_next.carry;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign alu_out   = alu_out_reg;
  assign carry_out = flags_reg.carry;
  assign sign      = flags_reg.sign;
  assign zero      = flags_reg.zero;
  assign parity    = flags_reg.parity;
  assign overflow  = flags_reg.overflow;

endmodule
